// File: rtl/cls_pkg.sv
// Shared types and constants for the core-lockstep voter.
package cls_pkg;

  typedef enum logic [1:0] {
    CLS_RUN     = 2'd0,
    CLS_RECOVER = 2'd1,
    CLS_HALT    = 2'd2
  } cls_state_e;

  localparam logic CLS_MODE_DETECT = 1'b0;
  localparam logic CLS_MODE_VOTE   = 1'b1;

  // Layout of one core's 71-bit compared bus.
  localparam int CLS_INSTR_REQ_OFS  = 0;
  localparam int CLS_INSTR_ADDR_OFS = 1;   // 16 bits
  localparam int CLS_DATA_REQ_OFS   = 17;
  localparam int CLS_DATA_WE_OFS    = 18;
  localparam int CLS_DATA_BE_OFS    = 19;  // 4 bits
  localparam int CLS_DATA_ADDR_OFS  = 23;  // 15 bits
  localparam int CLS_WDATA_OFS      = 38;  // 32 bits
  localparam int CLS_BUSY_OFS       = 70;
  localparam int CLS_BUS_W          = 71;

endpackage

// File: rtl/cls_majority.sv
// Combinational per-bit majority vote over the enabled cores, plus the
// per-core disagreement vector and its population count.
module cls_majority #(
  parameter int NUM_CORES = 3,
  parameter int BUS_W     = 71,
  parameter int CNT_W     = 2
) (
  input  logic [NUM_CORES*BUS_W-1:0] bus_i,
  input  logic [NUM_CORES-1:0]       en_i,
  output logic [BUS_W-1:0]           voted_o,
  output logic [NUM_CORES-1:0]       dis_o,
  output logic [CNT_W-1:0]           dis_cnt_o
);

  logic [CNT_W-1:0] n_en;
  logic [CNT_W-1:0] ones;
  logic             low_bit;
  logic             found;

  // Majority per bit; a tie falls back to the lowest-index enabled core.
  always_comb begin
    n_en      = '0;
    ones      = '0;
    low_bit   = 1'b0;
    found     = 1'b0;
    voted_o   = '0;
    dis_o     = '0;
    dis_cnt_o = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      n_en = n_en + CNT_W'(en_i[i]);
    end
    for (int b = 0; b < BUS_W; b++) begin
      ones    = '0;
      low_bit = 1'b0;
      found   = 1'b0;
      for (int i = 0; i < NUM_CORES; i++) begin
        if (en_i[i]) begin
          ones = ones + CNT_W'(bus_i[i*BUS_W+b]);
          if (!found) begin
            low_bit = bus_i[i*BUS_W+b];
            found   = 1'b1;
          end
        end
      end
      if ({ones, 1'b0} > {1'b0, n_en})
        voted_o[b] = 1'b1;
      else if ({ones, 1'b0} == {1'b0, n_en})
        voted_o[b] = low_bit;
      else
        voted_o[b] = 1'b0;
    end
    for (int i = 0; i < NUM_CORES; i++) begin
      dis_o[i]  = en_i[i] && (bus_i[i*BUS_W +: BUS_W] != voted_o);
      dis_cnt_o = dis_cnt_o + CNT_W'(dis_o[i]);
    end
  end

endmodule

// File: rtl/cls_vote_unit.sv
// N-way lockstep voter: majority bus to memory, fault classification,
// per-core error counters with masking, and bounded core-reset recovery.
module cls_vote_unit
  import cls_pkg::*;
#(
  parameter int NUM_CORES   = 3,
  parameter int BUS_W       = 71,
  parameter int ERR_CNT_W   = 4,
  parameter int ERR_THRESH  = 8,
  parameter int RST_CYCLES  = 16,
  parameter int MAX_RECOVER = 3
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           mode_i,
  input  logic                           clr_i,
  input  logic [NUM_CORES*BUS_W-1:0]     bus_i,
  output logic [BUS_W-1:0]               voted_o,
  output logic [NUM_CORES-1:0]           core_en_o,
  output logic [NUM_CORES-1:0]           mismatch_o,
  output logic [NUM_CORES*ERR_CNT_W-1:0] err_cnt_o,
  output logic                           core_rst_o,
  output logic                           fault_o,
  output logic [1:0]                     state_o
);

  localparam int CNT_W = $clog2(NUM_CORES + 1);
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int REC_W = $clog2(MAX_RECOVER + 1);
  localparam logic [ERR_CNT_W-1:0] CNT_MAX = '1;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + ERR_CNT_W'(1);
  endfunction

  function automatic logic [CNT_W-1:0] popcnt(input logic [NUM_CORES-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_CORES; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  cls_state_e             state_q;
  logic [RST_W-1:0]       rst_cnt_q;
  logic [REC_W-1:0]       rec_cnt_q;
  logic [NUM_CORES-1:0]   en_q;
  logic [NUM_CORES-1:0]   mismatch_p1;
  logic [ERR_CNT_W-1:0]   cnt_q [NUM_CORES];
  logic                   fault_q;

  logic [NUM_CORES-1:0]   dis_vec;
  logic [CNT_W-1:0]       dis_cnt;

  cls_majority #(
    .NUM_CORES (NUM_CORES),
    .BUS_W     (BUS_W),
    .CNT_W     (CNT_W)
  ) u_majority (
    .bus_i     (bus_i),
    .en_i      (en_q),
    .voted_o   (voted_o),
    .dis_o     (dis_vec),
    .dis_cnt_o (dis_cnt)
  );

  logic [CNT_W-1:0]     n_en;
  logic                 check;
  logic                 corr_ok;
  logic                 corr;
  logic                 uncorr;
  logic [ERR_CNT_W-1:0] cnt_inc [NUM_CORES];
  logic [NUM_CORES-1:0] thr_hit;
  logic [NUM_CORES-1:0] en_try;
  logic                 mask_halt;
  logic [REC_W-1:0]     rec_inc;
  logic                 rec_halt;

  // Classify the current cycle and precompute counter/mask/recovery updates.
  always_comb begin
    n_en    = popcnt(en_q);
    check   = (state_q == CLS_RUN) && (n_en >= CNT_W'(2));
    corr_ok = (mode_i == CLS_MODE_VOTE) && (n_en >= CNT_W'(3)) &&
              (dis_cnt <= ((n_en - CNT_W'(1)) >> 1));
    corr    = check && (dis_cnt != '0) && corr_ok;
    uncorr  = check && (dis_cnt != '0) && !corr_ok;
    thr_hit = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      cnt_inc[i] = dis_vec[i] ? sat_inc(cnt_q[i]) : cnt_q[i];
      thr_hit[i] = dis_vec[i] && (cnt_inc[i] >= ERR_CNT_W'(ERR_THRESH));
    end
    // A clear in the same cycle wins, so no threshold can be crossed then.
    en_try    = en_q & ~(clr_i ? '0 : thr_hit);
    mask_halt = corr && (popcnt(en_try) < CNT_W'(2));
    rec_inc   = rec_cnt_q + REC_W'(1);
    rec_halt  = (rec_inc >= REC_W'(MAX_RECOVER));
  end

  // Recovery FSM, counters, enable mask and registered disagreement vector.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= CLS_RECOVER;
      rst_cnt_q   <= RST_W'(RST_CYCLES);
      rec_cnt_q   <= '0;
      en_q        <= '1;
      mismatch_p1 <= '0;
      fault_q     <= 1'b0;
      for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
    end else begin
      mismatch_p1 <= '0;
      case (state_q)
        CLS_RUN: begin
          if (check) begin
            mismatch_p1 <= dis_vec;
            if (uncorr) begin
              rec_cnt_q <= rec_inc;
              if (rec_halt) begin
                state_q <= CLS_HALT;
                fault_q <= 1'b1;
              end else begin
                state_q     <= CLS_RECOVER;
                rst_cnt_q   <= RST_W'(RST_CYCLES);
                mismatch_p1 <= '0;
              end
            end else if (corr) begin
              for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= cnt_inc[i];
              if (mask_halt) begin
                state_q <= CLS_HALT;
                fault_q <= 1'b1;
              end else begin
                en_q <= en_try;
              end
            end
          end
        end
        CLS_RECOVER: begin
          rst_cnt_q <= rst_cnt_q - RST_W'(1);
          if (rst_cnt_q == RST_W'(1)) state_q <= CLS_RUN;
        end
        default: state_q <= CLS_HALT;
      endcase
      if (clr_i) begin
        rec_cnt_q <= '0;
        for (int i = 0; i < NUM_CORES; i++) cnt_q[i] <= '0;
      end
    end
  end

  // Flatten counters and drive status outputs from registered state.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) err_cnt_o[i*ERR_CNT_W +: ERR_CNT_W] = cnt_q[i];
    core_en_o  = en_q;
    mismatch_o = mismatch_p1;
    core_rst_o = (state_q != CLS_RUN);
    fault_o    = fault_q;
    state_o    = state_q;
  end

endmodule
